rs_request_credit: RTL and testbench

RS_REQUEST_CREDIT -- requirements
Module: rs_request_credit

---
 rtl/rs_request_credit_pkg.sv | 18 +
 rtl/rs_credit_counter.sv | 55 +++++
 rtl/rs_request_credit.sv | 84 ++++++++
 tb/tb_rs_request_credit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_request_credit_pkg.sv
// Shared reservation-station constants: RS type codes and default sizing
// for the dispatch credit logic.
package rs_request_credit_pkg;

  typedef enum logic [2:0] {
    RS_NONE   = 3'd0,
    RS_ALU    = 3'd1,
    RS_BRANCH = 3'd2,
    RS_MUL    = 3'd3,
    RS_LDST   = 3'd4
  } rs_type_e;

  localparam int RS_DISPATCH_WIDTH = 2;
  localparam int RS_NUM_TYPES      = 4;
  localparam int RS_TYPE_W         = 3;
  localparam int RS_DEPTH_DEF      = 8;

endpackage

// File: rtl/rs_credit_counter.sv
// Free-entry counter for one RS type: consume on fire, +1 on release, refill on flush.
// One-cycle update latency; saturates at RS_DEPTH and raises a sticky overflow flag.
module rs_credit_counter
  import rs_request_credit_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEF,
  parameter int CNT_W    = $clog2(RS_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [CNT_W-1:0] consume_i,
  input  logic             fire_i,
  input  logic             release_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] credit_o,
  output logic             overflow_o
);

  localparam logic [CNT_W:0]   FULL_EXT = (CNT_W + 1)'(RS_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RS_DEPTH);

  logic [CNT_W-1:0] credit_q, credit_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W:0]   sum;

  // One extra bit of headroom so a release on a full counter is detectable.
  always_comb begin
    sum = {1'b0, credit_q} + {{CNT_W{1'b0}}, release_i};
    if (fire_i) begin
      sum = sum - {1'b0, consume_i};
    end
    credit_d = sum[CNT_W-1:0];
    ovf_d    = ovf_q;
    if (flush_i) begin
      credit_d = FULL_CNT;
    end else if (sum > FULL_EXT) begin
      credit_d = FULL_CNT;
      ovf_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      credit_q <= FULL_CNT;
      ovf_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

  assign credit_o   = credit_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/rs_request_credit.sv
// All-or-nothing dispatch credit check across RS types; requests/ready are combinational, credits update 1 cycle later.
// Dispatch group stalls (no partial consumption) whenever any type lacks credit; flush refills, reset wins over all.
module rs_request_credit
  import rs_request_credit_pkg::*;
#(
  parameter int DISPATCH_WIDTH = RS_DISPATCH_WIDTH,
  parameter int NUM_RS         = RS_NUM_TYPES,
  parameter int TYPE_W         = RS_TYPE_W,
  parameter int RS_DEPTH       = RS_DEPTH_DEF,
  parameter int CNT_W          = $clog2(RS_DEPTH + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [DISPATCH_WIDTH-1:0]        inst_valid_i,
  input  logic [DISPATCH_WIDTH*TYPE_W-1:0] inst_rs_type_i,
  input  logic                             dispatch_en_i,
  input  logic                             flush_i,
  input  logic [NUM_RS-1:0]                release_i,
  output logic [DISPATCH_WIDTH*NUM_RS-1:0] req_o,
  output logic [NUM_RS*CNT_W-1:0]          req_num_o,
  output logic [NUM_RS*CNT_W-1:0]          credit_o,
  output logic                             dispatch_ready_o,
  output logic                             dispatch_fire_o,
  output logic                             overflow_err_o
);

  logic [CNT_W-1:0]  req_num_a [NUM_RS];
  logic [CNT_W-1:0]  credit_a  [NUM_RS];
  logic [NUM_RS-1:0] ovf_a;
  logic [NUM_RS-1:0] type_ok;

  // Codes 0 and anything above NUM_RS match no column and so request nothing.
  always_comb begin
    req_o = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      for (int t = 0; t < NUM_RS; t++) begin
        req_o[k*NUM_RS+t] = inst_valid_i[k] &&
                            (inst_rs_type_i[k*TYPE_W +: TYPE_W] == TYPE_W'(t + 1));
      end
    end
  end

  always_comb begin
    for (int t = 0; t < NUM_RS; t++) begin
      req_num_a[t] = '0;
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        req_num_a[t] = req_num_a[t] + CNT_W'(req_o[k*NUM_RS+t]);
      end
    end
  end

  always_comb begin
    req_num_o = '0;
    credit_o  = '0;
    type_ok   = '0;
    for (int t = 0; t < NUM_RS; t++) begin
      req_num_o[t*CNT_W +: CNT_W] = req_num_a[t];
      credit_o[t*CNT_W +: CNT_W]  = credit_a[t];
      type_ok[t]                  = (req_num_a[t] <= credit_a[t]);
    end
  end

  assign dispatch_ready_o = &type_ok;
  assign dispatch_fire_o  = reset_i & dispatch_ready_o & dispatch_en_i &
                            (|inst_valid_i) & ~flush_i;
  assign overflow_err_o   = |ovf_a;

  for (genvar g = 0; g < NUM_RS; g++) begin : g_cnt
    rs_credit_counter #(
      .RS_DEPTH (RS_DEPTH),
      .CNT_W    (CNT_W)
    ) u_cnt (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .consume_i  (req_num_a[g]),
      .fire_i     (dispatch_fire_o),
      .release_i  (release_i[g]),
      .flush_i    (flush_i),
      .credit_o   (credit_a[g]),
      .overflow_o (ovf_a[g])
    );
  end

endmodule

// File: tb/tb_rs_request_credit.sv
// Directed vector table, reset/flush corner sequences, then randomized traffic against a counting model.
module tb_rs_request_credit;
  import rs_request_credit_pkg::*;

  localparam int DW  = 2;
  localparam int NR  = 4;
  localparam int TW  = 3;
  localparam int DEP = 8;
  localparam int CW  = 4;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [DW-1:0]     inst_valid_i;
  logic [DW*TW-1:0]  inst_rs_type_i;
  logic              dispatch_en_i;
  logic              flush_i;
  logic [NR-1:0]     release_i;
  logic [DW*NR-1:0]  req_o;
  logic [NR*CW-1:0]  req_num_o;
  logic [NR*CW-1:0]  credit_o;
  logic              dispatch_ready_o;
  logic              dispatch_fire_o;
  logic              overflow_err_o;

  always #5 clk_i = ~clk_i;

  rs_request_credit dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .inst_valid_i     (inst_valid_i),
    .inst_rs_type_i   (inst_rs_type_i),
    .dispatch_en_i    (dispatch_en_i),
    .flush_i          (flush_i),
    .release_i        (release_i),
    .req_o            (req_o),
    .req_num_o        (req_num_o),
    .credit_o         (credit_o),
    .dispatch_ready_o (dispatch_ready_o),
    .dispatch_fire_o  (dispatch_fire_o),
    .overflow_err_o   (overflow_err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic [1:0]  vld;
    logic [5:0]  typ;
    logic        en;
    logic        fl;
    logic [3:0]  rel;
    logic [7:0]  e_req;
    logic [15:0] e_rn;
    logic        e_rdy;
    logic        e_fire;
    logic [15:0] e_cred;   // {LDST,MUL,BR,ALU} after the edge
    logic        e_ovf;
  } vec_t;

  function automatic vec_t mk(input logic rst_n, input logic [1:0] vld, input logic [5:0] typ,
                              input logic en, input logic fl, input logic [3:0] rel,
                              input logic [7:0] e_req, input logic [15:0] e_rn,
                              input logic e_rdy, input logic e_fire,
                              input logic [15:0] e_cred, input logic e_ovf);
    vec_t v;
    v.rst_n = rst_n; v.vld = vld; v.typ = typ; v.en = en; v.fl = fl; v.rel = rel;
    v.e_req = e_req; v.e_rn = e_rn; v.e_rdy = e_rdy; v.e_fire = e_fire;
    v.e_cred = e_cred; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic drive(input logic rst_n, input logic [1:0] vld, input logic [5:0] typ,
                       input logic en, input logic fl, input logic [3:0] rel);
    reset_i        = rst_n;
    inst_valid_i   = vld;
    inst_rs_type_i = typ;
    dispatch_en_i  = en;
    flush_i        = fl;
    release_i      = rel;
  endtask

  task automatic apply(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk_i);
    drive(v.rst_n, v.vld, v.typ, v.en, v.fl, v.rel);
    #1;
    chk({tag, ".req"},     32'(req_o),            32'(v.e_req));
    chk({tag, ".req_num"}, 32'(req_num_o),        32'(v.e_rn));
    chk({tag, ".ready"},   32'(dispatch_ready_o), 32'(v.e_rdy));
    chk({tag, ".fire"},    32'(dispatch_fire_o),  32'(v.e_fire));
    @(posedge clk_i);
    #1;
    chk({tag, ".credit"},  32'(credit_o),         32'(v.e_cred));
    chk({tag, ".ovf"},     32'(overflow_err_o),   32'(v.e_ovf));
  endtask

  vec_t tbl[$];

  int           mcred [NR];
  logic         movf;
  int           rn    [NR];
  logic [1:0]   r_v;
  logic [5:0]   r_ty;
  logic         r_en, r_fl, r_rs, e_rdy, e_fire;
  logic [3:0]   r_rl;
  logic [7:0]   e_req;
  logic [15:0]  e_rn, e_cr;
  int           nxt;

  initial begin
    drive(1'b0, 2'b11, {RS_ALU, RS_ALU}, 1'b1, 1'b0, 4'b0000);
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset.credit", 32'(credit_o), 32'h8888);
    chk("reset.ovf",    32'(overflow_err_o), 32'h0);
    chk("reset.fire",   32'(dispatch_fire_o), 32'h0);

    //               rst  vld    typ                     en   fl   rel      req    rn        rdy  fire cred      ovf
    tbl.push_back(mk(1'b1, 2'b11, {RS_ALU, RS_ALU},       1'b1, 1'b0, 4'b0000, 8'h11, 16'h0002, 1'b1, 1'b1, 16'h8886, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_ALU, RS_ALU},       1'b1, 1'b0, 4'b0000, 8'h11, 16'h0002, 1'b1, 1'b1, 16'h8884, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_ALU, RS_ALU},       1'b1, 1'b0, 4'b0000, 8'h11, 16'h0002, 1'b1, 1'b1, 16'h8882, 1'b0));
    tbl.push_back(mk(1'b1, 2'b01, {RS_ALU, RS_ALU},       1'b1, 1'b0, 4'b0000, 8'h01, 16'h0001, 1'b1, 1'b1, 16'h8881, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_ALU, RS_ALU},       1'b1, 1'b0, 4'b0000, 8'h11, 16'h0002, 1'b0, 1'b0, 16'h8881, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_MUL, RS_ALU},       1'b1, 1'b0, 4'b0000, 8'h41, 16'h0101, 1'b1, 1'b1, 16'h8780, 1'b0));
    tbl.push_back(mk(1'b1, 2'b01, {RS_ALU, RS_ALU},       1'b1, 1'b0, 4'b0001, 8'h01, 16'h0001, 1'b0, 1'b0, 16'h8781, 1'b0));
    tbl.push_back(mk(1'b1, 2'b01, {RS_ALU, RS_ALU},       1'b1, 1'b0, 4'b0000, 8'h01, 16'h0001, 1'b1, 1'b1, 16'h8780, 1'b0));
    tbl.push_back(mk(1'b1, 2'b00, {RS_ALU, RS_ALU},       1'b1, 1'b0, 4'b1000, 8'h00, 16'h0000, 1'b1, 1'b0, 16'h8780, 1'b1));
    tbl.push_back(mk(1'b1, 2'b11, {RS_MUL, RS_MUL},       1'b1, 1'b0, 4'b0100, 8'h44, 16'h0200, 1'b1, 1'b1, 16'h8680, 1'b1));
    tbl.push_back(mk(1'b1, 2'b11, {RS_LDST, RS_BRANCH},   1'b0, 1'b0, 4'b0000, 8'h82, 16'h1010, 1'b1, 1'b0, 16'h8680, 1'b1));
    tbl.push_back(mk(1'b1, 2'b11, {RS_LDST, RS_BRANCH},   1'b1, 1'b0, 4'b0000, 8'h82, 16'h1010, 1'b1, 1'b1, 16'h7670, 1'b1));
    tbl.push_back(mk(1'b1, 2'b11, {RS_BRANCH, RS_BRANCH}, 1'b1, 1'b1, 4'b0001, 8'h22, 16'h0020, 1'b1, 1'b0, 16'h8888, 1'b1));
    tbl.push_back(mk(1'b0, 2'b11, {RS_ALU, RS_ALU},       1'b1, 1'b0, 4'b1000, 8'h11, 16'h0002, 1'b1, 1'b0, 16'h8888, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_ALU, RS_ALU},       1'b1, 1'b0, 4'b0000, 8'h11, 16'h0002, 1'b1, 1'b1, 16'h8886, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_ALU, RS_ALU},       1'b1, 1'b0, 4'b0000, 8'h11, 16'h0002, 1'b1, 1'b1, 16'h8884, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_BRANCH, RS_ALU},    1'b1, 1'b0, 4'b0000, 8'h21, 16'h0011, 1'b1, 1'b1, 16'h8873, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_BRANCH, RS_BRANCH}, 1'b1, 1'b0, 4'b0000, 8'h22, 16'h0020, 1'b1, 1'b1, 16'h8853, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_MUL, RS_MUL},       1'b1, 1'b0, 4'b0000, 8'h44, 16'h0200, 1'b1, 1'b1, 16'h8653, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_MUL, RS_MUL},       1'b1, 1'b0, 4'b0000, 8'h44, 16'h0200, 1'b1, 1'b1, 16'h8453, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_MUL, RS_MUL},       1'b1, 1'b0, 4'b0000, 8'h44, 16'h0200, 1'b1, 1'b1, 16'h8253, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_MUL, RS_MUL},       1'b1, 1'b0, 4'b0000, 8'h44, 16'h0200, 1'b1, 1'b1, 16'h8053, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_LDST, RS_LDST},     1'b1, 1'b0, 4'b0000, 8'h88, 16'h2000, 1'b1, 1'b1, 16'h6053, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_LDST, RS_LDST},     1'b1, 1'b0, 4'b0000, 8'h88, 16'h2000, 1'b1, 1'b1, 16'h4053, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_LDST, RS_LDST},     1'b1, 1'b0, 4'b0000, 8'h88, 16'h2000, 1'b1, 1'b1, 16'h2053, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {RS_ALU, RS_ALU},       1'b1, 1'b1, 4'b0100, 8'h11, 16'h0002, 1'b1, 1'b0, 16'h8888, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {3'd5, RS_NONE},        1'b1, 1'b0, 4'b0000, 8'h00, 16'h0000, 1'b1, 1'b1, 16'h8888, 1'b0));
    tbl.push_back(mk(1'b1, 2'b11, {3'd6, 3'd7},           1'b1, 1'b0, 4'b0000, 8'h00, 16'h0000, 1'b1, 1'b1, 16'h8888, 1'b0));
    tbl.push_back(mk(1'b1, 2'b00, {RS_NONE, RS_NONE},     1'b0, 1'b0, 4'b1111, 8'h00, 16'h0000, 1'b1, 1'b0, 16'h8888, 1'b1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset landing on a firing group must discard its consumption entirely.
    @(negedge clk_i);
    drive(1'b1, 2'b11, {RS_ALU, RS_ALU}, 1'b1, 1'b0, 4'b0000);
    @(posedge clk_i); #1;
    chk("midrst.pre_credit", 32'(credit_o), 32'h8886);
    @(negedge clk_i);
    drive(1'b0, 2'b11, {RS_ALU, RS_ALU}, 1'b1, 1'b0, 4'b0001);
    #1;
    chk("midrst.fire_forced", 32'(dispatch_fire_o), 32'h0);
    chk("midrst.req_num",     32'(req_num_o),       32'h0002);
    @(posedge clk_i); #1;
    chk("midrst.credit", 32'(credit_o),       32'h8888);
    chk("midrst.ovf",    32'(overflow_err_o), 32'h0);

    // Releases are ignored under flush, so no overflow from a full type.
    @(negedge clk_i);
    drive(1'b1, 2'b00, {RS_NONE, RS_NONE}, 1'b0, 1'b1, 4'b1111);
    @(posedge clk_i); #1;
    chk("flushrel.credit", 32'(credit_o),       32'h8888);
    chk("flushrel.ovf",    32'(overflow_err_o), 32'h0);

    for (int t = 0; t < NR; t++) mcred[t] = DEP;
    movf = 1'b0;

    for (int n = 0; n < 600; n++) begin
      @(negedge clk_i);
      r_v  = 2'($urandom_range(0, 3));
      r_ty = {3'($urandom_range(0, 6)), 3'($urandom_range(0, 6))};
      r_en = ($urandom_range(0, 3) != 0);
      r_fl = ($urandom_range(0, 19) == 0);
      r_rs = ($urandom_range(0, 39) != 0);
      for (int t = 0; t < NR; t++) r_rl[t] = ($urandom_range(0, 3) == 0);
      drive(r_rs, r_v, r_ty, r_en, r_fl, r_rl);

      e_req = '0;
      e_rn  = '0;
      e_rdy = 1'b1;
      for (int t = 0; t < NR; t++) begin
        rn[t] = 0;
        for (int k = 0; k < DW; k++) begin
          if (r_v[k] && (int'(r_ty[k*TW +: TW]) == t + 1)) begin
            rn[t]++;
            e_req[k*NR + t] = 1'b1;
          end
        end
        e_rn[t*CW +: CW] = 4'(rn[t]);
        if (rn[t] > mcred[t]) e_rdy = 1'b0;
      end
      e_fire = r_rs && e_rdy && r_en && (r_v != 2'b00) && !r_fl;

      #1;
      chk("rnd.req",     32'(req_o),            32'(e_req));
      chk("rnd.req_num", 32'(req_num_o),        32'(e_rn));
      chk("rnd.ready",   32'(dispatch_ready_o), 32'(e_rdy));
      chk("rnd.fire",    32'(dispatch_fire_o),  32'(e_fire));

      for (int t = 0; t < NR; t++) begin
        if (!r_rs || r_fl) begin
          mcred[t] = DEP;
        end else begin
          nxt = mcred[t] - (e_fire ? rn[t] : 0) + int'(r_rl[t]);
          if (nxt > DEP) begin
            nxt  = DEP;
            movf = 1'b1;
          end
          mcred[t] = nxt;
        end
      end
      if (!r_rs) movf = 1'b0;

      e_cr = '0;
      for (int t = 0; t < NR; t++) e_cr[t*CW +: CW] = 4'(mcred[t]);

      @(posedge clk_i); #1;
      chk("rnd.credit", 32'(credit_o),       32'(e_cr));
      chk("rnd.ovf",    32'(overflow_err_o), 32'(movf));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
